reg_to_obi_master: RTL and testbench

REG_TO_OBI_MASTER -- requirements
Module: reg_to_obi_master

---
 rtl/reg_to_obi_master.sv | 168 ++++++++++++++++
 tb/tb_reg_to_obi_master.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_to_obi_master.sv
`default_nettype none
// ============================================================================
// Module      : reg_to_obi_master
// Description : Register-bus to OBI master bridge; one outstanding transaction,
//               optional timeout abort and a sticky stray-response flag.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_to_obi_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    reg_valid_i,
    input  logic                    reg_write_i,
    input  logic [ADDR_WIDTH-1:0]   reg_addr_i,
    input  logic [DATA_WIDTH-1:0]   reg_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] reg_wstrb_i,
    output logic                    reg_ready_o,
    output logic [DATA_WIDTH-1:0]   reg_rdata_o,
    output logic                    reg_error_o,
    output logic                    obi_req_o,
    output logic                    obi_we_o,
    output logic [ADDR_WIDTH-1:0]   obi_addr_o,
    output logic [DATA_WIDTH/8-1:0] obi_be_o,
    output logic [DATA_WIDTH-1:0]   obi_wdata_o,
    input  logic                    obi_gnt_i,
    input  logic                    obi_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   obi_rdata_i,
    output logic                    stray_rvalid_o
);

    localparam int C_BE_W  = DATA_WIDTH / 8;
    localparam int C_CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? C_CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [C_CNT_W-1:0] C_CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_WAIT_R = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic                    req_q, req_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [C_BE_W-1:0]       be_q, be_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    ready_q, ready_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    error_q, error_d;
    logic                    stray_q, stray_d;
    logic [C_CNT_W-1:0]      cnt_q, cnt_d;

    logic [C_CNT_W-1:0]      w_cnt_inc;
    logic                    w_timeout;

    assign w_cnt_inc = (cnt_q == C_CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    // Fires on the cycle whose increment would reach TIMEOUT_CYCLES, so the
    // request is live for exactly TIMEOUT_CYCLES cycles before the abort.
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (cnt_q >= C_CNT_LAST);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        ready_d = 1'b0;
        rdata_d = rdata_q;
        error_d = error_q;
        cnt_d   = cnt_q;
        // Only WAIT_R owns a response; rvalid anywhere else is unsolicited.
        stray_d = stray_q | (obi_rvalid_i & (state_q != S_WAIT_R));

        case (state_q)
            S_IDLE: begin
                if (reg_valid_i) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    we_d    = reg_write_i;
                    addr_d  = reg_addr_i;
                    wdata_d = reg_wdata_i;
                    be_d    = reg_write_i ? reg_wstrb_i : {C_BE_W{1'b1}};
                    cnt_d   = '0;
                end
            end
            S_REQ: begin
                cnt_d = w_cnt_inc;
                if (obi_gnt_i) begin
                    state_d = S_WAIT_R;
                    req_d   = 1'b0;
                end else if (w_timeout) begin
                    state_d = S_RESP;
                    req_d   = 1'b0;
                    ready_d = 1'b1;
                    error_d = 1'b1;
                    rdata_d = '0;
                end
            end
            S_WAIT_R: begin
                cnt_d = w_cnt_inc;
                if (obi_rvalid_i) begin
                    state_d = S_RESP;
                    ready_d = 1'b1;
                    error_d = 1'b0;
                    rdata_d = we_q ? '0 : obi_rdata_i;
                end else if (w_timeout) begin
                    state_d = S_RESP;
                    ready_d = 1'b1;
                    error_d = 1'b1;
                    rdata_d = '0;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            error_q <= 1'b0;
            stray_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
            stray_q <= stray_d;
            cnt_q   <= cnt_d;
        end
    end

    assign reg_ready_o    = ready_q;
    assign reg_rdata_o    = rdata_q;
    assign reg_error_o    = error_q;
    assign obi_req_o      = req_q;
    assign obi_we_o       = we_q;
    assign obi_addr_o     = addr_q;
    assign obi_be_o       = be_q;
    assign obi_wdata_o    = wdata_q;
    assign stray_rvalid_o = stray_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_to_obi_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_to_obi_master
// Description : Scenario bench for reg_to_obi_master with a scoreboard of
//               expected responses; DUT built with TIMEOUT_CYCLES = 8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_to_obi_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_valid, reg_write;
    logic [31:0] reg_addr, reg_wdata;
    logic [3:0]  reg_wstrb;
    logic        reg_ready_o, reg_error_o;
    logic [31:0] reg_rdata_o;
    logic        obi_req_o, obi_we_o;
    logic [31:0] obi_addr_o, obi_wdata_o;
    logic [3:0]  obi_be_o;
    logic        obi_gnt, obi_rvalid;
    logic [31:0] obi_rdata;
    logic        stray_rvalid_o;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    reg_to_obi_master #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .reg_valid_i   (reg_valid),
        .reg_write_i   (reg_write),
        .reg_addr_i    (reg_addr),
        .reg_wdata_i   (reg_wdata),
        .reg_wstrb_i   (reg_wstrb),
        .reg_ready_o   (reg_ready_o),
        .reg_rdata_o   (reg_rdata_o),
        .reg_error_o   (reg_error_o),
        .obi_req_o     (obi_req_o),
        .obi_we_o      (obi_we_o),
        .obi_addr_o    (obi_addr_o),
        .obi_be_o      (obi_be_o),
        .obi_wdata_o   (obi_wdata_o),
        .obi_gnt_i     (obi_gnt),
        .obi_rvalid_i  (obi_rvalid),
        .obi_rdata_i   (obi_rdata),
        .stray_rvalid_o(stray_rvalid_o)
    );

    // Drives one register request and plays an OBI slave: grant after
    // gnt_delay request cycles (-1 = never), rvalid rv_delay cycles after the
    // grant (-1 = never); spur injects rvalid on the first request cycle.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input logic [31:0] bus_rdata,
                           input int gnt_delay, input int rv_delay, input bit spur,
                           output int lat, output int req_cycles, output bit stable,
                           output bit got, output logic [31:0] rd, output logic er);
        logic [31:0] a0, w0;
        logic [3:0]  b0;
        logic        we0;
        bit          granted;
        int          wait_c;
        a0 = '0; w0 = '0; b0 = '0; we0 = 1'b0;
        reg_valid = 1'b1; reg_write = we; reg_addr = addr; reg_wdata = wdata; reg_wstrb = wstrb;
        lat = 0; req_cycles = 0; stable = 1'b1; got = 1'b0; rd = '0; er = 1'b0;
        granted = 1'b0; wait_c = 0;
        for (int i = 0; i < 40; i++) begin
            obi_gnt = 1'b0; obi_rvalid = 1'b0; obi_rdata = '0;
            if (obi_req_o) begin
                if (req_cycles == 0) begin
                    a0 = obi_addr_o; w0 = obi_wdata_o; b0 = obi_be_o; we0 = obi_we_o;
                end else if (obi_addr_o !== a0 || obi_wdata_o !== w0 ||
                             obi_be_o !== b0 || obi_we_o !== we0) begin
                    stable = 1'b0;
                end
                if (spur && req_cycles == 0) begin
                    obi_rvalid = 1'b1; obi_rdata = 32'hBAD0_BAD0;
                end
                req_cycles++;
                if (gnt_delay >= 0 && req_cycles - 1 >= gnt_delay) obi_gnt = 1'b1;
            end else if (granted && rv_delay >= 0) begin
                if (wait_c == rv_delay) begin
                    obi_rvalid = 1'b1; obi_rdata = bus_rdata;
                end
                wait_c++;
            end
            @(posedge clk); #1;
            if (obi_gnt) granted = 1'b1;
            lat++;
            if (reg_ready_o) begin
                got = 1'b1; rd = reg_rdata_o; er = reg_error_o;
                break;
            end
        end
        reg_valid = 1'b0; obi_gnt = 1'b0; obi_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (obi_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", obi_req_o); end
        checks++;
        if (reg_ready_o !== 1'b0 || reg_error_o !== 1'b0) begin
            errors++; $display("FAIL reset_ready_err: got %b/%b want 0/0", reg_ready_o, reg_error_o);
        end
        checks++;
        if (stray_rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_stray: got %b want 0", stray_rvalid_o); end
        checks++;
        if (reg_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", reg_rdata_o); end
        checks++;
        if (obi_addr_o !== 32'h0 || obi_be_o !== 4'h0 || obi_wdata_o !== 32'h0 || obi_we_o !== 1'b0) begin
            errors++; $display("FAIL reset_obi: got addr %h be %h wdata %h we %b want zeros",
                               obi_addr_o, obi_be_o, obi_wdata_o, obi_we_o);
        end
    endtask

    // Reset is released just before the call, so acceptance on the very
    // first edge is part of the three-cycle latency check.
    task automatic test_read_zero_wait();
        int lat, rc; bit st, got; logic [31:0] rd; logic er; exp_t e;
        sb.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0});
        run_txn(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 0, 1'b0, lat, rc, st, got, rd, er);
        checks++;
        if (!got) begin errors++; $display("FAIL read_ready: got none want one pulse"); end
        checks++;
        if (lat != 3) begin errors++; $display("FAIL read_latency: got %0d want 3", lat); end
        e = sb.pop_front();
        checks++;
        if (rd !== e.rdata || er !== e.err) begin
            errors++; $display("FAIL read_resp: got %h/%b want %h/%b", rd, er, e.rdata, e.err);
        end
        checks++;
        if (obi_be_o !== 4'hF || obi_addr_o !== 32'h10 || obi_we_o !== 1'b0) begin
            errors++; $display("FAIL read_addr_phase: got be %h addr %h we %b want F/10/0", obi_be_o, obi_addr_o, obi_we_o);
        end
        @(posedge clk); #1;
        checks++;
        if (reg_ready_o !== 1'b0 || reg_rdata_o !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL read_hold: got ready %b rdata %h want 0/deadbeef", reg_ready_o, reg_rdata_o);
        end
    endtask

    task automatic test_write_wait();
        int lat, rc; bit st, got; logic [31:0] rd; logic er; exp_t e;
        @(posedge clk); #1;
        sb.push_back('{rdata: 32'h0, err: 1'b0});
        run_txn(1'b1, 32'h20, 32'h1234_5678, 4'h3, 32'hFFFF_FFFF, 4, 0, 1'b0, lat, rc, st, got, rd, er);
        checks++;
        if (rc != 5) begin errors++; $display("FAIL write_req_cycles: got %0d want 5", rc); end
        checks++;
        if (!st) begin errors++; $display("FAIL write_stable: got unstable want stable"); end
        checks++;
        if (obi_addr_o !== 32'h20 || obi_be_o !== 4'h3 || obi_wdata_o !== 32'h1234_5678 || obi_we_o !== 1'b1) begin
            errors++; $display("FAIL write_addr_phase: got %h/%h/%h/%b want 20/3/12345678/1",
                               obi_addr_o, obi_be_o, obi_wdata_o, obi_we_o);
        end
        e = sb.pop_front();
        checks++;
        if (!got || rd !== e.rdata || er !== e.err || lat != 7) begin
            errors++; $display("FAIL write_resp: got ready %b %h/%b lat %0d want 1 %h/%b lat 7",
                               got, rd, er, lat, e.rdata, e.err);
        end
    endtask

    task automatic test_timeout_no_gnt();
        int lat, rc; bit st, got; logic [31:0] rd; logic er; exp_t e;
        @(posedge clk); #1;
        sb.push_back('{rdata: 32'h0, err: 1'b1});
        run_txn(1'b0, 32'h30, 32'h0, 4'h0, 32'h0, -1, -1, 1'b0, lat, rc, st, got, rd, er);
        checks++;
        if (rc != 8) begin errors++; $display("FAIL timeout_req_cycles: got %0d want 8", rc); end
        e = sb.pop_front();
        checks++;
        if (!got || rd !== e.rdata || er !== e.err || lat != 9) begin
            errors++; $display("FAIL timeout_resp: got ready %b %h/%b lat %0d want 1 %h/%b lat 9",
                               got, rd, er, lat, e.rdata, e.err);
        end
        checks++;
        if (obi_req_o !== 1'b0) begin errors++; $display("FAIL timeout_req_drop: got %b want 0", obi_req_o); end
    endtask

    task automatic test_handshake_wins();
        int lat, rc; bit st, got; logic [31:0] rd; logic er; exp_t e;
        @(posedge clk); #1;
        sb.push_back('{rdata: 32'hA5A5_0001, err: 1'b0});
        run_txn(1'b0, 32'h40, 32'h0, 4'h0, 32'hA5A5_0001, 7, 0, 1'b0, lat, rc, st, got, rd, er);
        e = sb.pop_front();
        checks++;
        if (!got || rc != 8 || lat != 10 || rd !== e.rdata || er !== e.err) begin
            errors++; $display("FAIL handshake_wins: got ready %b rc %0d lat %0d %h/%b want 1 8 10 %h/%b",
                               got, rc, lat, rd, er, e.rdata, e.err);
        end
    endtask

    task automatic test_back_to_back();
        int gnts, readies, outst, max_out, r0, r1;
        bit overlap; exp_t e;
        gnts = 0; readies = 0; outst = 0; max_out = 0; r0 = -1; r1 = -1; overlap = 1'b0;
        @(posedge clk); #1;
        sb.push_back('{rdata: 32'h1111_1111, err: 1'b0});
        sb.push_back('{rdata: 32'h2222_2222, err: 1'b0});
        reg_valid = 1'b1; reg_write = 1'b0; reg_addr = 32'h80; reg_wdata = '0; reg_wstrb = '0;
        for (int i = 0; i < 20 && readies < 2; i++) begin
            obi_gnt    = obi_req_o;
            obi_rvalid = (outst == 1) && !obi_req_o;
            obi_rdata  = (readies == 0) ? 32'h1111_1111 : 32'h2222_2222;
            if (obi_req_o && outst != 0) overlap = 1'b1;
            @(posedge clk); #1;
            if (obi_gnt) begin gnts++; outst++; end
            if (obi_rvalid) outst--;
            if (outst > max_out) max_out = outst;
            if (reg_ready_o) begin
                if (readies == 0) r0 = i; else r1 = i;
                readies++;
                e = sb.pop_front();
                checks++;
                if (reg_rdata_o !== e.rdata || reg_error_o !== e.err) begin
                    errors++; $display("FAIL b2b_resp: got %h/%b want %h/%b", reg_rdata_o, reg_error_o, e.rdata, e.err);
                end
            end
        end
        reg_valid = 1'b0; obi_gnt = 1'b0; obi_rvalid = 1'b0;
        checks++;
        if (readies != 2 || gnts != 2) begin
            errors++; $display("FAIL b2b_count: got ready %0d gnt %0d want 2/2", readies, gnts);
        end
        checks++;
        if (overlap || max_out > 1) begin
            errors++; $display("FAIL b2b_outstanding: got max %0d overlap %b want <=1 0", max_out, overlap);
        end
        checks++;
        if (r1 - r0 != 4) begin errors++; $display("FAIL b2b_spacing: got %0d want 4", r1 - r0); end
    endtask

    task automatic test_late_rvalid();
        int lat, rc, extra; bit st, got; logic [31:0] rd; logic er; exp_t e;
        @(posedge clk); #1;
        checks++;
        if (stray_rvalid_o !== 1'b0) begin errors++; $display("FAIL late_stray_pre: got %b want 0", stray_rvalid_o); end
        sb.push_back('{rdata: 32'h0, err: 1'b1});
        run_txn(1'b0, 32'h50, 32'h0, 4'h0, 32'h5555_5555, 0, 20, 1'b0, lat, rc, st, got, rd, er);
        e = sb.pop_front();
        checks++;
        if (!got || lat != 9 || rd !== e.rdata || er !== e.err) begin
            errors++; $display("FAIL late_timeout_resp: got ready %b lat %0d %h/%b want 1 9 %h/%b",
                               got, lat, rd, er, e.rdata, e.err);
        end
        extra = 0;
        for (int i = 0; i < 16; i++) begin
            obi_rvalid = (i == 10); obi_rdata = 32'h5555_5555;
            @(posedge clk); #1;
            if (reg_ready_o) extra++;
        end
        obi_rvalid = 1'b0;
        checks++;
        if (stray_rvalid_o !== 1'b1 || extra != 0) begin
            errors++; $display("FAIL late_stray: got stray %b extra ready %0d want 1/0", stray_rvalid_o, extra);
        end
    endtask

    task automatic test_reset_mid();
        int extra;
        @(posedge clk); #1;
        reg_valid = 1'b1; reg_write = 1'b1; reg_addr = 32'h60; reg_wdata = 32'hCAFE_F00D; reg_wstrb = 4'hF;
        @(posedge clk); #1;
        obi_gnt = obi_req_o;
        @(posedge clk); #1;
        obi_gnt = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obi_req_o !== 1'b0 || obi_addr_o !== 32'h0 || obi_wdata_o !== 32'h0 ||
            obi_be_o !== 4'h0 || obi_we_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_obi: got req %b addr %h wdata %h be %h we %b want zeros",
                               obi_req_o, obi_addr_o, obi_wdata_o, obi_be_o, obi_we_o);
        end
        checks++;
        if (reg_ready_o !== 1'b0 || reg_error_o !== 1'b0 || reg_rdata_o !== 32'h0 || stray_rvalid_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_reg: got %b/%b/%h stray %b want zeros",
                               reg_ready_o, reg_error_o, reg_rdata_o, stray_rvalid_o);
        end
        reg_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            obi_rvalid = (i == 1); obi_rdata = 32'h7777_7777;
            @(posedge clk); #1;
            if (reg_ready_o) extra++;
        end
        obi_rvalid = 1'b0;
        checks++;
        if (stray_rvalid_o !== 1'b1 || extra != 0 || obi_req_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_after: got stray %b ready %0d req %b want 1/0/0",
                               stray_rvalid_o, extra, obi_req_o);
        end
    endtask

    task automatic test_spurious_in_req();
        int lat, rc; bit st, got; logic [31:0] rd; logic er; exp_t e;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.push_back('{rdata: 32'h0BEE_F00D, err: 1'b0});
        run_txn(1'b0, 32'h70, 32'h0, 4'h0, 32'h0BEE_F00D, 2, 1, 1'b1, lat, rc, st, got, rd, er);
        e = sb.pop_front();
        checks++;
        if (!got || lat != 6 || rd !== e.rdata || er !== e.err) begin
            errors++; $display("FAIL spurious_resp: got ready %b lat %0d %h/%b want 1 6 %h/%b",
                               got, lat, rd, er, e.rdata, e.err);
        end
        checks++;
        if (stray_rvalid_o !== 1'b1) begin errors++; $display("FAIL spurious_stray: got %b want 1", stray_rvalid_o); end
    endtask

    initial begin
        rst = 1'b1;
        reg_valid = 1'b0; reg_write = 1'b0; reg_addr = '0; reg_wdata = '0; reg_wstrb = '0;
        obi_gnt = 1'b0; obi_rvalid = 1'b0; obi_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        test_read_zero_wait();
        test_write_wait();
        test_timeout_no_gnt();
        test_handshake_wins();
        test_back_to_back();
        test_late_rvalid();
        test_reset_mid();
        test_spurious_in_req();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
